serial_buff_ctrl: RTL and testbench
===================================

# serial_buff_ctrl

Sequencer for the serial-to-parallel receive buffer. It gates the buffer's shift enable while a frame of NDATA bits arrives, then issues the single parallel-load command. When nibble readout is enabled, it steps the buffer's 4-bit rotate so a downstream consumer can read the frame one nibble at a time from the buffer's top four bits, using a valid/ack handshake. It sits between the bit-level front end (which supplies the bit strobe) and the frame consumer, and it drives the buffer's `ena` and `cntin` lines.

## Interface

Parameters:
- NDATA, 128 — frame length in bits; power of two, ≥ 8; must equal the buffer's NDATA.
- NIBBLE_OUT, 1 — 1: rotate-out readout after load; 0: load only (for buffers built without rotate support).

Ports:
- clk  in  1  — single clock.
- rst  in  1  — synchronous, active-high reset.
- start  in  1  — begin a frame; sampled only in IDLE.
- bit_valid  in  1  — front-end strobe: the serial bit currently presented to the buffer is valid this cycle.
- nib_ack  in  1  — consumer has taken the current nibble; sampled only while nib_valid=1.
- ena  out  1  — buffer shift enable, combinational: bit_valid AND (state==SHIFT).
- cntin  out  log2(NDATA)  — buffer command, registered from state: 0 = LOAD, 4 = ROTATE, 1 = HOLD.
- busy  out  1  — high in every state except IDLE.
- nib_valid  out  1  — the buffer's top nibble (dout[NDATA-1:NDATA-4]) holds a valid frame nibble.
- nib_idx  out  log2(NDATA)-2  — index of the nibble presented; 0 = frame MSB nibble.
- done  out  1  — one-cycle pulse when the frame is finished.

## Operation

- States: IDLE, SHIFT, LOAD, NIB, ROT, DONE.
- IDLE: cntin=HOLD, ena=0, busy=0.
  - start=1 → SHIFT; bit_cnt cleared to 0.
- SHIFT: every cycle with bit_valid=1, ena=1 and bit_cnt increments.
  - bit_valid=1 with bit_cnt==NDATA-1 → LOAD. Exactly NDATA enabled shifts occur per frame.
  - Gaps in bit_valid of any length are allowed.
  - start is ignored.
- LOAD: cntin=0 for exactly one cycle.
  - NIBBLE_OUT=1 → NIB, nib_cnt=0.
  - NIBBLE_OUT=0 → DONE.
- NIB: cntin=HOLD, nib_valid=1, nib_idx=nib_cnt.
  - nib_ack=1 with nib_cnt==NDATA/4-1 → DONE.
  - nib_ack=1 otherwise → ROT, nib_cnt increments.
  - nib_ack=0 → stay in NIB; cntin is held, so the buffer contents are frozen.
- ROT: cntin=4 for exactly one cycle → NIB.
- DONE: done=1 for one cycle → IDLE. start is not sampled in DONE.
- Counters:
  - bit_cnt is log2(NDATA) bits wide and never wraps inside a frame.
  - nib_cnt is log2(NDATA)-2 bits wide.
- cntin never takes a value other than 0, 1 or 4. In particular, 0 appears only in LOAD.
- nib_ack outside NIB and bit_valid outside SHIFT are ignored.
- Reset: on the edge where rst=1, state → IDLE and counters → 0. From the following cycle:
  - cntin=1, busy=0, nib_valid=0, done=0, nib_idx=0, ena=0.
  - Reset mid-frame abandons the frame. No LOAD or ROT command is issued.
  - The buffer contents are left as they are; the buffer's own reset is driven separately by the top level.

## Timing

- Load latency: the last bit is shifted on edge E. LOAD is the state for cycle E→E+1 (cntin=0). The buffer updates dout on edge E+1.
- The first nib_valid=1 is the cycle after E+1, coincident with NIB state. The buffer dout is already valid then.
- Each ack → next nibble takes 2 cycles: edge A (ack sampled), ROT cycle, buffer rotates on edge A+1, and nib_valid re-asserts from A+1. nib_valid is low during ROT.
- Fastest frame with an always-acking consumer: NDATA shift cycles + 1 (LOAD) + (2·NDATA/4 − 1) + 1 (DONE).
- start is accepted in IDLE only. It may be held high; a held start restarts a new frame on the first IDLE cycle after DONE.

## Test plan

- NDATA=8, NIBBLE_OUT=1, bit_valid held high, start pulse, serial data 1010_0110 MSB-first, nib_ack always high:
  - exactly 8 ena cycles;
  - cntin sequence 0, 1, 4, 1;
  - nibbles 0xA (idx 0) then 0x6 (idx 1);
  - one done pulse;
  - busy low after DONE.
- Same frame, bit_valid on every third cycle:
  - ena pulses only on bit_valid cycles;
  - LOAD occurs one cycle after the 8th strobe;
  - result is identical.
- nib_ack withheld 5 cycles in NIB:
  - nib_valid stays 1 and cntin stays 1 throughout;
  - no rotate until ack.
- NIBBLE_OUT=0: after the 8th bit, cntin=0 for one cycle then DONE; nib_valid never asserts.
- rst asserted during SHIFT after 3 bits:
  - IDLE values from the next cycle;
  - cntin never 0;
  - a new start then needs a full 8 bits before LOAD.
- start held high continuously, NDATA=128:
  - back-to-back frames with no extra IDLE cycle beyond one;
  - 32 nibbles per frame;
  - nib_idx runs 0–31.

Source files
------------

// File: rtl/serial_buff_ctrl_if.sv
// serial_buff_ctrl_if: handshake and command bundle between the receive-buffer
// sequencer (slave side) and the front end / frame consumer (master side).
interface serial_buff_ctrl_if #(
  parameter int unsigned NDATA = 128
);
  localparam int unsigned CW = $clog2(NDATA);
  localparam int unsigned IW = CW - 2;

  // Front end and consumer requests
  logic          start;
  logic          bit_valid;
  logic          nib_ack;

  // Buffer command and status
  logic          ena;
  logic [CW-1:0] cntin;
  logic          busy;
  logic          nib_valid;
  logic [IW-1:0] nib_idx;
  logic          done;

  modport slave (
    input  start, bit_valid, nib_ack,
    output ena, cntin, busy, nib_valid, nib_idx, done
  );

  modport master (
    output start, bit_valid, nib_ack,
    input  ena, cntin, busy, nib_valid, nib_idx, done
  );
endinterface

// File: rtl/serial_buff_ctrl.sv
// serial_buff_ctrl: sequencer for the serial-to-parallel receive buffer.
// Gates the buffer shift enable for NDATA strobed bits, issues one parallel
// LOAD, then (optionally) steps the buffer's 4-bit rotate so the consumer can
// read the frame MSB nibble first from the buffer's top four bits.
module serial_buff_ctrl #(
  parameter int unsigned NDATA      = 128,
  parameter bit          NIBBLE_OUT = 1'b1
) (
  input logic               clk,
  input logic               rst,
  serial_buff_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(NDATA);
  localparam int unsigned NW = CW - 2;

  // Buffer command encodings on cntin
  localparam logic [CW-1:0] CMD_LOAD   = CW'(0);
  localparam logic [CW-1:0] CMD_HOLD   = CW'(1);
  localparam logic [CW-1:0] CMD_ROTATE = CW'(4);

  localparam logic [CW-1:0] BIT_LAST = CW'(NDATA - 1);
  localparam logic [NW-1:0] NIB_LAST = NW'(NDATA / 4 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_LOAD  = 3'd2,
    S_NIB   = 3'd3,
    S_ROT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [NW-1:0] nib_cnt_q;
  logic [CW-1:0] cntin_q;
  logic          busy_q;
  logic          nib_valid_q;
  logic [NW-1:0] nib_idx_q;
  logic          done_q;

  logic [CW-1:0] bit_cnt_d;
  logic [NW-1:0] nib_cnt_d;

  assign bit_cnt_d = bit_cnt_q + CW'(1);
  assign nib_cnt_d = nib_cnt_q + NW'(1);

  // Shift enable must follow the strobe in the same cycle, so it stays combinational
  assign bus.ena = bus.bit_valid & (state_q == S_SHIFT);

  assign bus.cntin     = cntin_q;
  assign bus.busy      = busy_q;
  assign bus.nib_valid = nib_valid_q;
  assign bus.nib_idx   = nib_idx_q;
  assign bus.done      = done_q;

  // Frame sequencer: state, counters and the registered command/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      nib_cnt_q   <= '0;
      cntin_q     <= CMD_HOLD;
      busy_q      <= 1'b0;
      nib_valid_q <= 1'b0;
      nib_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      // Outputs below describe the state being entered; most cycles hold the buffer
      cntin_q     <= CMD_HOLD;
      nib_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
      case (state_q)
        S_IDLE: begin
          busy_q <= bus.start;
          if (bus.start) begin
            state_q   <= S_SHIFT;
            bit_cnt_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (bus.bit_valid) begin
            if (bit_cnt_q == BIT_LAST) begin
              // Last bit is being shifted on this edge; parallel load follows
              state_q <= S_LOAD;
              cntin_q <= CMD_LOAD;
            end else begin
              bit_cnt_q <= bit_cnt_d;
            end
          end else begin
            state_q <= S_SHIFT;
          end
        end
        S_LOAD: begin
          if (NIBBLE_OUT) begin
            state_q     <= S_NIB;
            nib_cnt_q   <= '0;
            nib_valid_q <= 1'b1;
            nib_idx_q   <= '0;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_NIB: begin
          if (bus.nib_ack) begin
            if (nib_cnt_q == NIB_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              // Rotate brings the next nibble to the top; nib_valid drops for that cycle
              state_q   <= S_ROT;
              cntin_q   <= CMD_ROTATE;
              nib_cnt_q <= nib_cnt_d;
            end
          end else begin
            // Buffer is frozen while the consumer stalls
            state_q     <= S_NIB;
            nib_valid_q <= 1'b1;
          end
        end
        S_ROT: begin
          state_q     <= S_NIB;
          nib_valid_q <= 1'b1;
          nib_idx_q   <= nib_cnt_q;
        end
        S_DONE: begin
          // start is deliberately not looked at here
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          // Unreachable encodings fall back to a safe idle without touching the buffer
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_buff_ctrl.sv
// tb_serial_buff_ctrl: directed and randomized frames on three sequencer
// instances (8-bit with readout, 8-bit load-only, 128-bit with readout).
// Expected behaviour is derived from frame events (strobe count, last-strobe
// time, nibbles taken) and a stand-in receive buffer driven by the DUT commands.
module tb_serial_buff_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  serial_buff_ctrl_if #(.NDATA(8))   bus_a ();
  serial_buff_ctrl_if #(.NDATA(8))   bus_b ();
  serial_buff_ctrl_if #(.NDATA(128)) bus_c ();

  serial_buff_ctrl #(.NDATA(8),   .NIBBLE_OUT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  serial_buff_ctrl #(.NDATA(8),   .NIBBLE_OUT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  serial_buff_ctrl #(.NDATA(128), .NIBBLE_OUT(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  logic        i_start [3];
  logic        i_bv    [3];
  logic        i_ack   [3];
  logic        i_sd    [3];
  logic        o_ena   [3];
  logic [31:0] o_cntin [3];
  logic        o_busy  [3];
  logic        o_nv    [3];
  logic [31:0] o_idx   [3];
  logic        o_done  [3];
  logic [3:0]  o_top   [3];

  assign bus_a.start = i_start[0]; assign bus_a.bit_valid = i_bv[0]; assign bus_a.nib_ack = i_ack[0];
  assign bus_b.start = i_start[1]; assign bus_b.bit_valid = i_bv[1]; assign bus_b.nib_ack = i_ack[1];
  assign bus_c.start = i_start[2]; assign bus_c.bit_valid = i_bv[2]; assign bus_c.nib_ack = i_ack[2];

  assign o_ena[0] = bus_a.ena; assign o_ena[1] = bus_b.ena; assign o_ena[2] = bus_c.ena;
  assign o_cntin[0] = 32'(bus_a.cntin); assign o_cntin[1] = 32'(bus_b.cntin); assign o_cntin[2] = 32'(bus_c.cntin);
  assign o_busy[0] = bus_a.busy; assign o_busy[1] = bus_b.busy; assign o_busy[2] = bus_c.busy;
  assign o_nv[0] = bus_a.nib_valid; assign o_nv[1] = bus_b.nib_valid; assign o_nv[2] = bus_c.nib_valid;
  assign o_idx[0] = 32'(bus_a.nib_idx); assign o_idx[1] = 32'(bus_b.nib_idx); assign o_idx[2] = 32'(bus_c.nib_idx);
  assign o_done[0] = bus_a.done; assign o_done[1] = bus_b.done; assign o_done[2] = bus_c.done;

  logic [7:0]   sh_a, dout_a;
  logic [127:0] sh_c, dout_c;

  assign o_top[0] = dout_a[7:4];
  assign o_top[1] = 4'h0;
  assign o_top[2] = dout_c[127:124];

  // Receive buffer stand-in for the 8-bit readout instance
  always @(posedge clk) begin
    if (bus_a.ena) sh_a <= {sh_a[6:0], i_sd[0]};
    if (bus_a.cntin == 3'd0) dout_a <= sh_a;
    else if (bus_a.cntin == 3'd4) dout_a <= {dout_a[3:0], dout_a[7:4]};
  end

  // Receive buffer stand-in for the 128-bit readout instance
  always @(posedge clk) begin
    if (bus_c.ena) sh_c <= {sh_c[126:0], i_sd[2]};
    if (bus_c.cntin == 7'd0) dout_c <= sh_c;
    else if (bus_c.cntin == 7'd4) dout_c <= {dout_c[123:0], dout_c[127:124]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle with every instance expected idle; bit/ack strobes are noise
  task automatic idle_cycle(input bit check_idx);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      i_start[d] = 1'b0;
      i_bv[d]    = 1'($urandom_range(1));
      i_ack[d]   = 1'($urandom_range(1));
      i_sd[d]    = 1'($urandom_range(1));
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("idle_busy%0d", d), 32'(o_busy[d]), 32'd0);
      chk($sformatf("idle_cntin%0d", d), o_cntin[d], 32'd1);
      chk($sformatf("idle_nv%0d", d), 32'(o_nv[d]), 32'd0);
      chk($sformatf("idle_done%0d", d), 32'(o_done[d]), 32'd0);
      chk($sformatf("idle_ena%0d", d), 32'(o_ena[d]), 32'd0);
      if (check_idx) chk($sformatf("idle_idx%0d", d), o_idx[d], 32'd0);
    end
  endtask

  // One frame on instance d; cycle t=0 is the IDLE cycle in which start is presented.
  // bv_per>0 strobes every bv_per-th cycle, otherwise strobes with bv_pct percent.
  // ack_hold withholds the first ack for that many NIB cycles. rst_at>0 resets after that many bits.
  task automatic run_frame(input int d, input int n, input bit nibout, input logic [127:0] data,
                           input int bv_pct, input int bv_per, input int ack_pct, input int ack_hold,
                           input bit hold, input int rst_at, output int t_done);
    int nn, nstr, t_last, ntaken, t_take, held, budget;
    logic bv, ack, ex_ena, ex_nv, ex_done, in_rst;
    logic [31:0] ex_cnt;
    bit fin;
    nn = n / 4; nstr = 0; t_last = -10; ntaken = 0; t_take = -10; held = 0;
    t_done = -1; fin = 1'b0; budget = 20 * n + 200;
    for (int t = 0; t < budget && !fin; t++) begin
      @(negedge clk);
      rst = 1'b0;
      ex_nv   = nibout && (t_last >= 0) && (t >= t_last + 2) && (ntaken < nn) && (t != t_take + 1);
      ex_done = nibout ? (ntaken == nn && t == t_take + 1) : (t_last >= 0 && t == t_last + 2);
      if (t == t_last + 1) ex_cnt = 32'd0;
      else if (nibout && t == t_take + 1 && ntaken < nn) ex_cnt = 32'd4;
      else ex_cnt = 32'd1;
      if (t >= 1 && nstr < n) bv = (bv_per > 0) ? ((t % bv_per) == 0) : ($urandom_range(99) < bv_pct);
      else bv = 1'($urandom_range(1));
      in_rst = (rst_at > 0) && (nstr == rst_at) && (t >= 1);
      if (in_rst) begin
        rst = 1'b1;
        bv  = 1'b0;
      end
      ack = ($urandom_range(99) < ack_pct);
      if (ex_nv && held < ack_hold) begin
        ack = 1'b0;
        held++;
      end
      i_start[d] = (t == 0) || hold || ($urandom_range(1) == 1);
      i_bv[d]    = bv;
      i_ack[d]   = ack;
      i_sd[d]    = (nstr < n) ? data[n - 1 - nstr] : 1'($urandom_range(1));
      ex_ena     = bv && (t >= 1) && (nstr < n);
      #1;
      chk("ena", 32'(o_ena[d]), 32'(ex_ena));
      chk("cntin", o_cntin[d], ex_cnt);
      chk("nib_valid", 32'(o_nv[d]), 32'(ex_nv));
      chk("done", 32'(o_done[d]), 32'(ex_done));
      chk("busy", 32'(o_busy[d]), 32'(t >= 1));
      if (ex_nv) chk("nib_idx", o_idx[d], 32'(ntaken));
      if (ex_nv && ack) begin
        chk("nibble", 32'(o_top[d]), 32'(data[n - 1 - 4 * ntaken -: 4]));
        ntaken++;
        t_take = t;
      end
      if (ex_ena) begin
        nstr++;
        if (nstr == n) t_last = t;
      end
      if (ex_done) begin
        t_done = t;
        fin = 1'b1;
      end
      if (in_rst) fin = 1'b1;
    end
    if (rst_at == 0) chk("frame_done_seen", 32'(t_done >= 0), 32'd1);
  endtask

  initial begin
    int td;
    logic [127:0] dat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      i_start[d] = 1'b0; i_bv[d] = 1'b0; i_ack[d] = 1'b0; i_sd[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    idle_cycle(1'b1);

    // 1010_0110, strobe every cycle, consumer always acks
    run_frame(0, 8, 1'b1, 128'hA6, 100, 0, 100, 0, 1'b0, 0, td);
    chk("len_fast8", 32'(td), 32'd13);
    idle_cycle(1'b0);

    // Same frame, strobe on every third cycle
    run_frame(0, 8, 1'b1, 128'hA6, 0, 3, 100, 0, 1'b0, 0, td);
    chk("len_every3", 32'(td), 32'd29);
    idle_cycle(1'b0);

    // Consumer withholds the first ack for five NIB cycles
    run_frame(0, 8, 1'b1, 128'h5C, 100, 0, 100, 5, 1'b0, 0, td);
    chk("len_ackhold", 32'(td), 32'd18);
    idle_cycle(1'b0);

    // Load-only instance
    run_frame(1, 8, 1'b0, 128'hA6, 100, 0, 100, 0, 1'b0, 0, td);
    chk("len_loadonly", 32'(td), 32'd10);
    idle_cycle(1'b0);

    // Reset after three bits, then a full fresh frame
    run_frame(0, 8, 1'b1, 128'hA6, 100, 0, 100, 0, 1'b0, 3, td);
    idle_cycle(1'b1);
    run_frame(0, 8, 1'b1, 128'h3E, 100, 0, 100, 0, 1'b0, 0, td);
    chk("len_after_rst", 32'(td), 32'd13);
    idle_cycle(1'b0);

    // 128-bit frames back to back with start held high
    dat = {$urandom, $urandom, $urandom, $urandom};
    run_frame(2, 128, 1'b1, dat, 100, 0, 100, 0, 1'b1, 0, td);
    chk("len_128_first", 32'(td), 32'd193);
    dat = {$urandom, $urandom, $urandom, $urandom};
    run_frame(2, 128, 1'b1, dat, 100, 0, 100, 0, 1'b1, 0, td);
    chk("len_128_second", 32'(td), 32'd193);
    idle_cycle(1'b0);

    // Randomized frames with gapped strobes and a hesitant consumer
    for (int k = 0; k < 8; k++) begin
      dat = 128'($urandom_range(255));
      run_frame(k % 2, 8, (k % 2) == 0, dat, 60, 0, 50, 0, 1'b0, 0, td);
      idle_cycle(1'b0);
    end
    dat = {$urandom, $urandom, $urandom, $urandom};
    run_frame(2, 128, 1'b1, dat, 70, 0, 60, 0, 1'b0, 0, td);
    idle_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
